// File: rtl/div_restoring_seq_if.sv
// Handshake and operand/result bundle for div_restoring_seq.
// master: the requester that starts divisions and consumes results.
// slave : the divider itself.
interface div_restoring_seq_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  i_en;
  logic                  i_start;
  logic [DATA_WIDTH-1:0] iv_dividend;
  logic [DATA_WIDTH-1:0] iv_divisor;
  logic [DATA_WIDTH-1:0] ov_quot;
  logic [DATA_WIDTH-1:0] ov_rem;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_div_by_zero;

  modport master (
    output i_en, i_start, iv_dividend, iv_divisor,
    input  ov_quot, ov_rem, o_busy, o_done, o_div_by_zero
  );

  modport slave (
    input  i_en, i_start, iv_dividend, iv_divisor,
    output ov_quot, ov_rem, o_busy, o_done, o_div_by_zero
  );
endinterface

// File: rtl/div_restoring_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per enabled clock.
// A start accepted in IDLE or DONE runs DATA_WIDTH CALC steps; results are
// registered on the last step together with a one-cycle o_done pulse.
// Divide by zero is not special-cased: the restoring recurrence naturally
// yields quotient all-ones and remainder equal to the dividend.
// Optional build macro DIV_SIGNED_EN: two's-complement operands/results
// (magnitudes are divided, signs re-applied on the final step; quotient
// truncates toward zero, remainder follows the dividend's sign).
module div_restoring_seq #(
  parameter int DATA_WIDTH = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  div_restoring_seq_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;       // partial remainder
  logic [DATA_WIDTH-1:0] q_q, q_d;       // dividend shifting out / quotient shifting in
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;   // captured divisor (magnitude when signed)
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic                  dbz_q, dbz_d;

`ifdef DIV_SIGNED_EN
  logic                  sgn_quot_q, sgn_quot_d;
  logic                  sgn_rem_q, sgn_rem_d;
  logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag;
`endif

  logic [DATA_WIDTH:0]   r_sh;
  logic                  borrow;
  logic [DATA_WIDTH-1:0] r_step, q_step;
  logic                  start_ok;

  // One restoring step: shift {R,Q} left, trial-subtract the divisor.
  // The trial is evaluated DATA_WIDTH+1 bits wide; the compare gives its sign
  // and, when non-negative, the difference always fits in DATA_WIDTH bits.
  always_comb begin
    r_sh   = {r_q, q_q[DATA_WIDTH-1]};
    borrow = (r_sh < {1'b0, dvs_q});
    r_step = borrow ? r_sh[DATA_WIDTH-1:0] : (r_sh[DATA_WIDTH-1:0] - dvs_q);
    q_step = {q_q[DATA_WIDTH-2:0], ~borrow};
  end

  assign start_ok = bus.i_en && bus.i_start && (state_q != CALC);

`ifdef DIV_SIGNED_EN
  // Operand magnitudes; the most-negative value maps onto its unsigned pattern.
  always_comb begin
    dvd_mag = bus.iv_dividend[DATA_WIDTH-1] ? -bus.iv_dividend : bus.iv_dividend;
    dvs_mag = bus.iv_divisor[DATA_WIDTH-1]  ? -bus.iv_divisor  : bus.iv_divisor;
  end
`endif

  // Next-state and datapath update; nothing moves while i_en is low.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    sgn_quot_d = sgn_quot_q;
    sgn_rem_d  = sgn_rem_q;
`endif

    if (bus.i_en) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_d = CALC;
            cnt_d   = CW'(DATA_WIDTH);
            r_d     = '0;
`ifdef DIV_SIGNED_EN
            q_d        = dvd_mag;
            dvs_d      = dvs_mag;
            sgn_quot_d = bus.iv_dividend[DATA_WIDTH-1] ^ bus.iv_divisor[DATA_WIDTH-1];
            sgn_rem_d  = bus.iv_dividend[DATA_WIDTH-1];
`else
            q_d   = bus.iv_dividend;
            dvs_d = bus.iv_divisor;
`endif
          end else begin
            state_d = IDLE;
          end
        end

        CALC: begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            dbz_d   = (dvs_q == '0);
`ifdef DIV_SIGNED_EN
            quot_d = sgn_quot_q ? -q_step : q_step;
            rem_d  = sgn_rem_q  ? -r_step : r_step;
`else
            quot_d = q_step;
            rem_d  = r_step;
`endif
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: all datapath registers are reset too, so outputs are defined zeros right after reset.
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_quot_q <= 1'b0;
      sgn_rem_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      sgn_quot_q <= sgn_quot_d;
      sgn_rem_q  <= sgn_rem_d;
`endif
    end
  end

  assign bus.ov_quot       = quot_q;
  assign bus.ov_rem        = rem_q;
  assign bus.o_div_by_zero = dbz_q;
  assign bus.o_busy        = (state_q == CALC);
  assign bus.o_done        = (state_q == DONE);

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq at DATA_WIDTH=8: directed vector
// table, handshake corner sequences (back-to-back start, ignored start, stall,
// done stretch, mid-operation reset) and randomized operands against a
// plain-arithmetic reference model. Follows DIV_SIGNED_EN when defined.
module tb_div_restoring_seq;

  localparam int W = 8;

  logic i_clk;
  logic i_rst_n;

  div_restoring_seq_if #(.DATA_WIDTH(W)) bus ();

  div_restoring_seq #(.DATA_WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] exp_quot;
    logic [W-1:0] exp_rem;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    dbz = (sb == 0);
    if (sb == 0) begin
      q = (sa < 0) ? W'(1) : '1;
      r = a;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      q = a;
      r = '0;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
`else
    int ua, ub;
    ua  = int'(a);
    ub  = int'(b);
    dbz = (ub == 0);
    if (ub == 0) begin
      q = '1;
      r = a;
    end else begin
      q = W'(ua / ub);
      r = W'(ua % ub);
    end
`endif
  endtask

  // Issue one division (called #1 after an edge, DUT idle or in DONE) and
  // wait for o_done. Operands and i_start are scrambled while busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output int lat, output logic busy0);
    bus.i_en        = 1'b1;
    bus.i_start     = 1'b1;
    bus.iv_dividend = a;
    bus.iv_divisor  = b;
    @(posedge i_clk); #1;
    busy0 = bus.o_busy && !bus.o_done;
    lat   = 0;
    while (lat < 40) begin
      bus.i_start     = 1'($urandom_range(0, 1));
      bus.iv_dividend = 8'($urandom);
      bus.iv_divisor  = 8'($urandom);
      @(posedge i_clk); #1;
      lat++;
      if (bus.o_done) break;
    end
    bus.i_start = 1'b0;
    q   = bus.ov_quot;
    r   = bus.ov_rem;
    dbz = bus.o_div_by_zero;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q, r, eq, er;
    logic         dbz, edbz, busy0, seen;
    int           lat;

`ifdef DIV_SIGNED_EN
    vecs[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0};
    vecs[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
    vecs[2] = '{8'hF3, 8'h00, 8'h01, 8'hF3, 1'b1};
    vecs[3] = '{8'h0D, 8'h00, 8'hFF, 8'h0D, 1'b1};
    vecs[4] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0};
    vecs[5] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0};
    vecs[7] = '{8'h64, 8'h0A, 8'h0A, 8'h00, 1'b0};
`else
    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[3] = '{8'd13,  8'd0,   8'hFF,  8'd13,  1'b1};
    vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[5] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[7] = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0};
`endif

    bus.i_en        = 1'b0;
    bus.i_start     = 1'b0;
    bus.iv_dividend = '0;
    bus.iv_divisor  = '0;
    i_rst_n         = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset quot", 32'(bus.ov_quot), 32'd0);
    check("reset rem",  32'(bus.ov_rem),  32'd0);
    check("reset busy", 32'(bus.o_busy),  32'd0);
    check("reset done", 32'(bus.o_done),  32'd0);
    check("reset dbz",  32'(bus.o_div_by_zero), 32'd0);
    i_rst_n  = 1'b1;
    bus.i_en = 1'b1;
    @(posedge i_clk); #1;
    check("idle busy", 32'(bus.o_busy), 32'd0);

    // Directed table; consecutive entries restart in the DONE cycle.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].dividend, vecs[i].divisor, q, r, dbz, lat, busy0);
      check($sformatf("vec%0d busy after start", i), 32'(busy0), 32'd1);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d quot", i), 32'(q), 32'(vecs[i].exp_quot));
      check($sformatf("vec%0d rem", i),  32'(r), 32'(vecs[i].exp_rem));
      check($sformatf("vec%0d dbz", i),  32'(dbz), 32'(vecs[i].exp_dbz));
    end

    // Ignored mid-CALC start plus a 3-cycle enable stall.
    @(posedge i_clk); #1;
    model(8'd200, 8'd7, eq, er, edbz);
    bus.iv_dividend = 8'd200;
    bus.iv_divisor  = 8'd7;
    bus.i_start     = 1'b1;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    lat = 0;
    @(posedge i_clk); #1; lat++;
    bus.i_start     = 1'b1;
    bus.iv_dividend = 8'd9;
    bus.iv_divisor  = 8'd3;
    @(posedge i_clk); #1; lat++;
    bus.i_start = 1'b0;
    bus.i_en    = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1; lat++;
    end
    check("stall busy", 32'(bus.o_busy), 32'd1);
    check("stall done", 32'(bus.o_done), 32'd0);
    bus.i_en = 1'b1;
    while (lat < 40) begin
      @(posedge i_clk); #1; lat++;
      if (bus.o_done) break;
    end
    check("stall latency", 32'(lat), 32'd11);
    check("stall quot", 32'(bus.ov_quot), 32'(eq));
    check("stall rem",  32'(bus.ov_rem),  32'(er));

    // o_done stretches while disabled, then drops after one enabled edge.
    bus.i_en = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("stretch done", 32'(bus.o_done), 32'd1);
    bus.i_en = 1'b1;
    @(posedge i_clk); #1;
    check("done drop", 32'(bus.o_done), 32'd0);
    check("hold quot", 32'(bus.ov_quot), 32'(eq));
    check("hold rem",  32'(bus.ov_rem),  32'(er));

    // Asynchronous reset mid-CALC aborts immediately with no o_done.
    bus.iv_dividend = 8'd200;
    bus.iv_divisor  = 8'd7;
    bus.i_start     = 1'b1;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("abort quot", 32'(bus.ov_quot), 32'd0);
    check("abort rem",  32'(bus.ov_rem),  32'd0);
    check("abort busy", 32'(bus.o_busy),  32'd0);
    check("abort done", 32'(bus.o_done),  32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge i_clk); #1;
      if (bus.o_done || bus.o_busy) seen = 1'b1;
    end
    check("no done after abort", 32'(seen), 32'd0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 120; i++) begin
      logic [W-1:0] a, b;
      a = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 8'($urandom_range(1, 3));
        2:       b = '1;
        default: b = 8'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) begin
        @(posedge i_clk); #1;
      end
      model(a, b, eq, er, edbz);
      run_op(a, b, q, r, dbz, lat, busy0);
      check($sformatf("rnd%0d %0h/%0h latency", i, a, b), 32'(lat), 32'd8);
      check($sformatf("rnd%0d %0h/%0h quot", i, a, b), 32'(q), 32'(eq));
      check($sformatf("rnd%0d %0h/%0h rem", i, a, b),  32'(r), 32'(er));
      check($sformatf("rnd%0d %0h/%0h dbz", i, a, b),  32'(dbz), 32'(edbz));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
